// File: rtl/glitch_pkg.sv
// glitch_pkg: shared state encoding, engine defaults and sweep-point advance
package glitch_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_DELAY, S_PULSE, S_OBSERVE, S_COOLDOWN, S_DONE
  } glitch_state_t;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_DELAY_START = 0;
  localparam int DEF_DELAY_END = 1000;
  localparam int DEF_DELAY_STEP = 1;
  localparam int DEF_WIDTH_MIN = 1;
  localparam int DEF_WIDTH_MAX = 8;
  localparam int DEF_ATTEMPTS = 4;
  localparam int DEF_OBSERVE_CYCLES = 1000;
  localparam int DEF_COOLDOWN_CYCLES = 100;
  localparam bit DEF_STOP_ON_HIT = 1'b1;
  typedef struct packed {
    logic last;
    logic [63:0] width;
    logic [63:0] delay;
  } point_t;
  // Delay steps first; on overrun it rewinds and the width steps, and past the
  // last width the sweep is over. The 65-bit sum keeps a wrapped delay from
  // sneaking under the end bound.
  function automatic point_t next_point(input logic [63:0] delay, input logic [63:0] width,
                                        input logic [63:0] d_start, input logic [63:0] d_end,
                                        input logic [63:0] d_step, input logic [63:0] w_max);
    point_t p;
    logic [64:0] sum;
    sum = {1'b0, delay} + {1'b0, d_step};
    p.last = 1'b0;
    p.width = width;
    p.delay = sum[63:0];
    if (sum > {1'b0, d_end}) begin
      p.delay = d_start;
      if (width < w_max) p.width = width + 64'd1;
      else p.last = 1'b1;
    end
    return p;
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer with registered rising-edge detect
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);
  logic meta, sync_q, sync_qq;
  // Shift the pin through two metastability flops plus one history flop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {meta, sync_q, sync_qq} <= 3'b000;
    else {meta, sync_q, sync_qq} <= {din, meta, sync_q};
  assign level = sync_q;
  assign rise = sync_q & ~sync_qq;
endmodule

// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl: sweeps glitch width/delay/attempts and reports the first hit
module glitch_sweep_ctrl import glitch_pkg::*; #(
  parameter int               CNT_W           = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DELAY_START     = CNT_W'(DEF_DELAY_START),
  parameter logic [CNT_W-1:0] DELAY_END       = CNT_W'(DEF_DELAY_END),
  parameter logic [CNT_W-1:0] DELAY_STEP      = CNT_W'(DEF_DELAY_STEP),
  parameter logic [CNT_W-1:0] WIDTH_MIN       = CNT_W'(DEF_WIDTH_MIN),
  parameter logic [CNT_W-1:0] WIDTH_MAX       = CNT_W'(DEF_WIDTH_MAX),
  parameter logic [CNT_W-1:0] ATTEMPTS        = CNT_W'(DEF_ATTEMPTS),
  parameter logic [CNT_W-1:0] OBSERVE_CYCLES  = CNT_W'(DEF_OBSERVE_CYCLES),
  parameter logic [CNT_W-1:0] COOLDOWN_CYCLES = CNT_W'(DEF_COOLDOWN_CYCLES),
  parameter bit               STOP_ON_HIT     = DEF_STOP_ON_HIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             trigger,
  input  logic             target_ok,
  output logic             glitch,
  output logic             busy,
  output logic             delay_indicator,
  output logic             done_indicator,
  output logic             hit,
  output logic [CNT_W-1:0] hit_delay,
  output logic [CNT_W-1:0] hit_width,
  output logic [CNT_W-1:0] cur_delay,
  output logic [CNT_W-1:0] cur_width
);
  glitch_state_t state;
  logic [CNT_W-1:0] attempt, cnt;
  logic attempt_hit, trig_rise, ok_sync, trig_level_unused, ok_rise_unused;
  point_t np;
  sync_edge u_trig (.clk(clk), .rst_n(rst_n), .din(trigger), .level(trig_level_unused), .rise(trig_rise));
  sync_edge u_ok (.clk(clk), .rst_n(rst_n), .din(target_ok), .level(ok_sync), .rise(ok_rise_unused));
  // Next sweep point, used only when an attempt set is exhausted
  always_comb np = next_point(64'(cur_delay), 64'(cur_width), 64'(DELAY_START),
                              64'(DELAY_END), 64'(DELAY_STEP), 64'(WIDTH_MAX));
  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign delay_indicator = state == S_DELAY;
  assign done_indicator = state == S_DONE;
  // Sweep sequencer; cnt counts 1..N inside each timed state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      glitch <= 1'b0;
      hit <= 1'b0;
      hit_delay <= '0;
      hit_width <= '0;
      cur_delay <= DELAY_START;
      cur_width <= WIDTH_MIN;
      attempt <= '0;
      cnt <= '0;
      attempt_hit <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      glitch <= 1'b0;
    end else
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            hit <= 1'b0;
            hit_delay <= '0;
            hit_width <= '0;
            cur_delay <= DELAY_START;
            cur_width <= WIDTH_MIN;
            attempt <= '0;
            attempt_hit <= 1'b0;
            state <= S_ARM;
          end
        S_ARM:
          if (trig_rise) begin
            cnt <= CNT_W'(1);
            glitch <= cur_delay == '0;
            state <= (cur_delay == '0) ? S_PULSE : S_DELAY;
          end
        S_DELAY:
          if (cnt >= cur_delay) begin
            glitch <= 1'b1;
            cnt <= CNT_W'(1);
            state <= S_PULSE;
          end else cnt <= cnt + CNT_W'(1);
        S_PULSE:
          if (cnt >= cur_width) begin
            glitch <= 1'b0;
            cnt <= CNT_W'(1);
            state <= S_OBSERVE;
          end else cnt <= cnt + CNT_W'(1);
        S_OBSERVE: begin
          if (ok_sync) begin
            hit <= 1'b1;
            attempt_hit <= 1'b1;
            if (!hit) begin
              hit_delay <= cur_delay;
              hit_width <= cur_width;
            end
          end
          if (cnt >= OBSERVE_CYCLES) begin
            cnt <= CNT_W'(1);
            state <= S_COOLDOWN;
          end else cnt <= cnt + CNT_W'(1);
        end
        S_COOLDOWN:
          if (cnt >= COOLDOWN_CYCLES) begin
            attempt_hit <= 1'b0;
            if (attempt_hit && STOP_ON_HIT) state <= S_DONE;
            else if (attempt + CNT_W'(1) < ATTEMPTS) begin
              attempt <= attempt + CNT_W'(1);
              state <= S_ARM;
            end else begin
              attempt <= '0;
              cur_delay <= np.delay[CNT_W-1:0];
              cur_width <= np.width[CNT_W-1:0];
              state <= np.last ? S_DONE : S_ARM;
            end
          end else cnt <= cnt + CNT_W'(1);
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// tb_glitch_sweep_ctrl: directed vector and sequence checks of the sweep controller
module tb_glitch_sweep_ctrl;
  import glitch_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] start = '0, abort = '0, trig = '0, ok = '0;
  logic [2:0] glitch, busy, dly_ind, done_ind, hit;
  logic [31:0] hit_delay [3], hit_width [3], cur_delay [3], cur_width [3];
  int passed = 0, total = 0;
  typedef struct {int dut; logic [31:0] d; logic [31:0] w; bit drive_ok; bit st;} vec_t;
  vec_t vt [17];
  point_t np;

  always #5 clk = ~clk;

  glitch_sweep_ctrl #(.CNT_W(32), .DELAY_START(32'd2), .DELAY_END(32'd4), .DELAY_STEP(32'd1),
    .WIDTH_MIN(32'd1), .WIDTH_MAX(32'd2), .ATTEMPTS(32'd1), .OBSERVE_CYCLES(32'd8),
    .COOLDOWN_CYCLES(32'd4), .STOP_ON_HIT(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .trigger(trig[0]),
    .target_ok(ok[0]), .glitch(glitch[0]), .busy(busy[0]), .delay_indicator(dly_ind[0]),
    .done_indicator(done_ind[0]), .hit(hit[0]), .hit_delay(hit_delay[0]), .hit_width(hit_width[0]),
    .cur_delay(cur_delay[0]), .cur_width(cur_width[0]));

  glitch_sweep_ctrl #(.CNT_W(32), .DELAY_START(32'd2), .DELAY_END(32'd4), .DELAY_STEP(32'd1),
    .WIDTH_MIN(32'd1), .WIDTH_MAX(32'd2), .ATTEMPTS(32'd1), .OBSERVE_CYCLES(32'd8),
    .COOLDOWN_CYCLES(32'd4), .STOP_ON_HIT(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .trigger(trig[1]),
    .target_ok(ok[1]), .glitch(glitch[1]), .busy(busy[1]), .delay_indicator(dly_ind[1]),
    .done_indicator(done_ind[1]), .hit(hit[1]), .hit_delay(hit_delay[1]), .hit_width(hit_width[1]),
    .cur_delay(cur_delay[1]), .cur_width(cur_width[1]));

  glitch_sweep_ctrl #(.CNT_W(32), .DELAY_START(32'd0), .DELAY_END(32'hFFFF_FFFF),
    .DELAY_STEP(32'h8000_0000), .WIDTH_MIN(32'd4), .WIDTH_MAX(32'd4), .ATTEMPTS(32'd1),
    .OBSERVE_CYCLES(32'd8), .COOLDOWN_CYCLES(32'd4), .STOP_ON_HIT(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .trigger(trig[2]),
    .target_ok(ok[2]), .glitch(glitch[2]), .busy(busy[2]), .delay_indicator(dly_ind[2]),
    .done_indicator(done_ind[2]), .hit(hit[2]), .hit_delay(hit_delay[2]), .hit_width(hit_width[2]),
    .cur_delay(cur_delay[2]), .cur_width(cur_width[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick(1);
    start[i] = 1'b0;
  endtask

  // One trigger pulse: glitch must rise d+3 edges after the pin edge (2 sync + 1 edge
  // detect cycle + d delay cycles) and stay high for w cycles.
  task automatic run_point(input int i, input logic [31:0] d, input logic [31:0] w,
                           input bit drive_ok, input string tag);
    int n = 0, wd = 0;
    trig[i] = 1'b1;
    while (!glitch[i] && n < 60) begin
      tick(1);
      n++;
    end
    trig[i] = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(d) + 64'd3);
    check({tag, " cur_delay"}, 64'(cur_delay[i]), 64'(d));
    check({tag, " cur_width"}, 64'(cur_width[i]), 64'(w));
    while (glitch[i] && wd < 60) begin
      tick(1);
      wd++;
    end
    check({tag, " width"}, 64'(wd), 64'(w));
    if (drive_ok) begin
      ok[i] = 1'b1;
      tick(3);
      ok[i] = 1'b0;
      tick(17);
    end else tick(20);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      if (vt[k].st) begin
        pulse_start(vt[k].dut);
        check($sformatf("v%0d start busy", k), 64'(busy[vt[k].dut]), 64'd1);
        check($sformatf("v%0d start hit clr", k), 64'(hit[vt[k].dut]), 64'd0);
      end
      run_point(vt[k].dut, vt[k].d, vt[k].w, vt[k].drive_ok, $sformatf("v%0d", k));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, n;
    vt[0]  = '{0, 32'd2, 32'd1, 1'b0, 1'b1};
    vt[1]  = '{0, 32'd3, 32'd1, 1'b0, 1'b0};
    vt[2]  = '{0, 32'd4, 32'd1, 1'b0, 1'b0};
    vt[3]  = '{0, 32'd2, 32'd2, 1'b0, 1'b0};
    vt[4]  = '{0, 32'd3, 32'd2, 1'b0, 1'b0};
    vt[5]  = '{0, 32'd4, 32'd2, 1'b0, 1'b0};
    vt[6]  = '{0, 32'd2, 32'd1, 1'b0, 1'b1};
    vt[7]  = '{0, 32'd3, 32'd1, 1'b0, 1'b0};
    vt[8]  = '{0, 32'd4, 32'd1, 1'b0, 1'b0};
    vt[9]  = '{0, 32'd2, 32'd2, 1'b0, 1'b0};
    vt[10] = '{0, 32'd3, 32'd2, 1'b1, 1'b0};
    vt[11] = '{1, 32'd2, 32'd1, 1'b0, 1'b1};
    vt[12] = '{1, 32'd3, 32'd1, 1'b1, 1'b0};
    vt[13] = '{1, 32'd4, 32'd1, 1'b0, 1'b0};
    vt[14] = '{1, 32'd2, 32'd2, 1'b1, 1'b0};
    vt[15] = '{1, 32'd3, 32'd2, 1'b0, 1'b0};
    vt[16] = '{1, 32'd4, 32'd2, 1'b0, 1'b0};

    tick(2);
    check("rst glitch", 64'(glitch), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done_ind), 64'd0);
    check("rst hit", 64'(hit), 64'd0);
    check("rst cur_delay0", 64'(cur_delay[0]), 64'd2);
    check("rst cur_width0", 64'(cur_width[0]), 64'd1);
    check("rst cur_width2", 64'(cur_width[2]), 64'd4);
    rst_n = 1'b1;
    tick(2);

    run_vecs(0, 5);
    check("sweep done", 64'(done_ind[0]), 64'd1);
    check("sweep busy", 64'(busy[0]), 64'd0);
    check("sweep no hit", 64'(hit[0]), 64'd0);

    run_vecs(6, 10);
    check("stop done", 64'(done_ind[0]), 64'd1);
    check("stop hit", 64'(hit[0]), 64'd1);
    check("stop hit_delay", 64'(hit_delay[0]), 64'd3);
    check("stop hit_width", 64'(hit_width[0]), 64'd2);
    bad = 0;
    trig[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (glitch[0]) bad++;
    end
    trig[0] = 1'b0;
    check("stop no pulse", 64'(bad), 64'd0);

    run_vecs(11, 16);
    check("cont done", 64'(done_ind[1]), 64'd1);
    check("cont hit", 64'(hit[1]), 64'd1);
    check("cont hit_delay", 64'(hit_delay[1]), 64'd3);
    check("cont hit_width", 64'(hit_width[1]), 64'd1);

    np = next_point(64'd0, 64'd4, 64'd0, 64'hFFFF_FFFF, 64'h8000_0000, 64'd4);
    check("np step delay", np.delay, 64'h8000_0000);
    check("np step last", 64'(np.last), 64'd0);
    np = next_point(64'h8000_0000, 64'd4, 64'd0, 64'hFFFF_FFFF, 64'h8000_0000, 64'd4);
    check("np wrap last", 64'(np.last), 64'd1);
    check("np wrap delay", np.delay, 64'd0);
    np = next_point(64'd4, 64'd1, 64'd2, 64'd4, 64'd1, 64'd2);
    check("np width step", np.width, 64'd2);
    check("np width rewind", np.delay, 64'd2);
    np = next_point(64'd5, 64'd1, 64'd5, 64'd3, 64'd1, 64'd1);
    check("np degenerate last", 64'(np.last), 64'd1);

    pulse_start(2);
    run_point(2, 32'd0, 32'd4, 1'b0, "wrap0");
    check("wrap next delay", 64'(cur_delay[2]), 64'h8000_0000);
    check("wrap busy", 64'(busy[2]), 64'd1);
    trig[2] = 1'b1;
    tick(4);
    trig[2] = 1'b0;
    check("big delay ind", 64'(dly_ind[2]), 64'd1);
    tick(20);
    check("big delay still", 64'(dly_ind[2]), 64'd1);
    check("big delay no glitch", 64'(glitch[2]), 64'd0);
    abort[2] = 1'b1;
    tick(1);
    abort[2] = 1'b0;
    check("abort delay busy", 64'(busy[2]), 64'd0);
    check("abort delay ind", 64'(dly_ind[2]), 64'd0);
    start[2] = 1'b1;
    abort[2] = 1'b1;
    tick(1);
    start[2] = 1'b0;
    abort[2] = 1'b0;
    check("start+abort busy", 64'(busy[2]), 64'd0);
    pulse_start(2);
    check("restart delay", 64'(cur_delay[2]), 64'd0);
    check("restart width", 64'(cur_width[2]), 64'd4);
    n = 0;
    trig[2] = 1'b1;
    while (!glitch[2] && n < 60) begin
      tick(1);
      n++;
    end
    trig[2] = 1'b0;
    check("abort pulse latency", 64'(n), 64'd3);
    tick(1);
    check("abort pulse 2nd", 64'(glitch[2]), 64'd1);
    abort[2] = 1'b1;
    tick(1);
    abort[2] = 1'b0;
    check("abort pulse glitch", 64'(glitch[2]), 64'd0);
    check("abort pulse busy", 64'(busy[2]), 64'd0);

    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    check("abort done state", 64'(done_ind[0]), 64'd0);
    check("abort keeps hit", 64'(hit[0]), 64'd1);
    check("abort keeps hit_delay", 64'(hit_delay[0]), 64'd3);

    pulse_start(0);
    check("restart hit clr", 64'(hit[0]), 64'd0);
    check("restart hit_delay clr", 64'(hit_delay[0]), 64'd0);
    pulse_start(2);
    trig[0] = 1'b1;
    trig[2] = 1'b1;
    tick(6);
    check("pre-rst glitch2", 64'(glitch[2]), 64'd1);
    check("pre-rst glitch0", 64'(glitch[0]), 64'd0);
    check("pre-rst busy0", 64'(busy[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async glitch", 64'(glitch), 64'd0);
    check("async busy", 64'(busy), 64'd0);
    check("async hit", 64'(hit), 64'd0);
    check("async hit_delay1", 64'(hit_delay[1]), 64'd0);
    check("async cur_delay0", 64'(cur_delay[0]), 64'd2);
    trig[2] = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    pulse_start(0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (glitch[0] || dly_ind[0]) bad++;
    end
    check("held trig no attempt", 64'(bad), 64'd0);
    check("held trig armed", 64'(busy[0]), 64'd1);
    trig[0] = 1'b0;
    tick(4);
    run_point(0, 32'd2, 32'd1, 1'b0, "retrig");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/glitch_sweep_ctrl.md
Name: glitch_sweep_ctrl

Overview:
- Scheduler for the delay/pulse glitch datapath. Automates parameter search instead of fixed delay/width.
- Steps glitch width (outer loop), delay (middle loop) and attempt count (inner loop).
- Each attempt: arm, wait for target trigger edge, count delay, drive glitch pulse, observe target response window, cool down.
- Sits between the PLL-clocked domain logic and the target board pins. Reports the first successful (delay, width) point.

Parameters:
CNT_W, 32, width of delay/width/attempt/window counters
DELAY_START, 0, first delay point (clk cycles after trigger edge)
DELAY_END, 1000, last delay point, inclusive
DELAY_STEP, 1, delay increment; must be >= 1
WIDTH_MIN, 1, first glitch width in clk cycles; must be >= 1
WIDTH_MAX, 8, last glitch width, inclusive
ATTEMPTS, 4, attempts per (delay, width) point; must be >= 1
OBSERVE_CYCLES, 1000, response window length after pulse ends
COOLDOWN_CYCLES, 100, idle gap before re-arming
STOP_ON_HIT, 1, 1 = finish on first hit; 0 = record first hit and continue sweep

Ports:
clk  in  1  system clock (PLL output domain)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins sweep from IDLE or DONE
abort  in  1  level; forces return to IDLE from any state
trigger  in  1  asynchronous target trigger; rising edge starts an attempt
target_ok  in  1  asynchronous target success flag, sampled during OBSERVE
glitch  out  1  glitch pulse to crowbar/clock-mux stage
busy  out  1  high in every state except IDLE and DONE
delay_indicator  out  1  high in DELAY state
done_indicator  out  1  high in DONE state
hit  out  1  sticky; set when target_ok is seen; cleared on start
hit_delay  out  CNT_W  delay of first hit
hit_width  out  CNT_W  width of first hit
cur_delay  out  CNT_W  delay point under test
cur_width  out  CNT_W  width point under test

Behaviour:
- Reset values:
  - All outputs 0.
  - cur_delay = DELAY_START, cur_width = WIDTH_MIN.
  - State IDLE.
  - Synchronizer flops 0.
- Input synchronization:
  - trigger and target_ok each pass through a 2-flop synchronizer.
  - trig_rise = sync_q & ~sync_qq (registered edge detect).
  - Response is therefore 3 clk after the pin edge. Measured delay is referenced to the trig_rise cycle.
- States: IDLE, ARM, DELAY, PULSE, OBSERVE, COOLDOWN, DONE.
- IDLE / DONE:
  - On start: clear hit, hit_delay, hit_width.
  - Load cur_delay = DELAY_START, cur_width = WIDTH_MIN, attempt = 0.
  - Go to ARM.
- ARM: wait for trig_rise.
  - If cur_delay = 0, go to PULSE; otherwise go to DELAY.
- DELAY: lasts exactly cur_delay cycles, then PULSE.
- PULSE:
  - glitch is registered high for exactly cur_width cycles.
  - First high cycle is cur_delay+1 cycles after the trig_rise cycle.
  - Then OBSERVE.
- OBSERVE: lasts OBSERVE_CYCLES cycles.
  - Any cycle with synced target_ok = 1 sets hit.
  - If this is the first hit, captures cur_delay/cur_width into hit_delay/hit_width.
  - A hit is recorded at most once per sweep.
  - Window always runs to completion.
- COOLDOWN: lasts COOLDOWN_CYCLES cycles, then advances:
  - If hit was set this attempt and STOP_ON_HIT = 1, go to DONE.
  - Else if attempt+1 < ATTEMPTS: attempt++, go to ARM.
  - Else attempt = 0. If cur_delay + DELAY_STEP <= DELAY_END, cur_delay += DELAY_STEP.
  - Else cur_delay = DELAY_START. If cur_width < WIDTH_MAX, cur_width++, go to ARM; else go to DONE.
  - Compare the sum at CNT_W+1 bits so wrap-around never passes the end check.
- abort: highest priority in every state.
  - Next state IDLE, glitch deasserted the next cycle.
  - hit, hit_delay and hit_width retained.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- rst_n asserted mid-pulse: glitch drops immediately (asynchronous clear).
- Trigger edges outside ARM are ignored. Trigger held high does not retrigger; a new rising edge is required.
- Degenerate parameters:
  - DELAY_START > DELAY_END: single delay point DELAY_START.
  - WIDTH_MIN > WIDTH_MAX: single width point.

Decomposition:
- Package glitch_pkg holds:
  - state enum typedef glitch_state_t (3-bit).
  - localparam defaults shared with the fixed glitch engine.
  - Function next_point(), which computes the delay/width advance.
- One sub-module, sync_edge: 2-flop synchronizer plus rising-edge detect with async active-low reset. Instantiated for trigger and target_ok; edge output unused for target_ok.

Test Plan:
- DELAY_START=2, DELAY_END=4, STEP=1, WIDTH 1..2, ATTEMPTS=1, target_ok=0:
  - start, then one trigger pulse per ARM.
  - Expect 6 pulses with (delay, width) = (2,1),(3,1),(4,1),(2,2),(3,2),(4,2).
  - glitch rises exactly delay+1 clk after trig_rise.
  - done_indicator=1 and hit=0 at end.
- Same sweep, target_ok driven high during OBSERVE of point (3,2), STOP_ON_HIT=1:
  - hit=1, hit_delay=3, hit_width=2.
  - DONE reached with no further glitch pulses.
- STOP_ON_HIT=0, same hit at (3,1):
  - Sweep completes all 6 points.
  - hit_delay=3, hit_width=1 unchanged by later points.
- abort asserted during the 2nd cycle of a width-4 pulse:
  - glitch low on the next clk, state IDLE, busy=0.
  - A subsequent start restarts from DELAY_START/WIDTH_MIN.
- rst_n low mid-OBSERVE:
  - All outputs 0 immediately, without a clk edge.
  - Trigger held high across release causes no attempt until low-then-high.
- DELAY_START=0, DELAY_END=0xFFFFFFFF, DELAY_STEP=0x80000000, CNT_W=32:
  - Delay points 0, 0x80000000 only; no wrap to a third point.
  - Delay 0 pulse rises 1 clk after trig_rise.
